fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Parametrised instruction-fetch stage with a prefetch queue. Sits between the
//  instruction ROM and the decode stage of the ASIP.
//  Generalises the single stall-able fetch/decode register: it adds a DEPTH-entry
//  buffer of {pc, instr}, a valid handshake and branch redirect/flush.
//  Keeps issuing ROM reads while decode is stalled, until the queue is full.
// PARAMETERS
//  INST_W    24  instruction width
//  ADDR_W    16  PC / ROM address width
//  DEPTH     4   queue entries; power of two, >= 2
//  PC_STEP   1   PC increment per fetched instruction
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  clk          in   1       single clock; the ROM is also clocked on clk
//  reset        in   1       asynchronous, active-low reset
//  rom_addr     out  ADDR_W  ROM read address (= fetch PC register)
//  rom_data     in   INST_W  ROM output; valid one cycle after rom_addr
//  stall_d      in   1       decode cannot accept the head entry this cycle
//  redirect     in   1       branch taken: flush and refetch
//  redirect_pc  in   ADDR_W  new fetch PC when redirect=1
//  instr_d      out  INST_W  head instruction; 0 when valid_d=0
//  pc_d         out  ADDR_W  PC of head instruction; 0 when valid_d=0
//  valid_d      out  1       head entry present (count != 0)
//  count        out  $clog2(DEPTH)+1  entries currently queued
// BEHAVIOUR
//  Reset (async, reset=0): pc=RESET_PC, count=0, rd/wr ptr=0, inflight=0.
//   Outputs: valid_d=0, instr_d=0, pc_d=0, rom_addr=RESET_PC, applied immediately.
//   A reset mid-operation discards all queued and in-flight entries.
//  pop   = valid_d & ~stall_d & ~redirect; head is removed at the clock edge.
//  issue = ~redirect & (count + inflight - pop < DEPTH).
//   On issue: inflight<=1, inflight_pc<=pc, pc<=pc+PC_STEP (wraps mod 2^ADDR_W).
//   Otherwise inflight<=0 and pc holds.
//  push  = inflight & ~redirect; writes {inflight_pc, rom_data} at the tail.
//  Push and pop in the same cycle: count unchanged; legal when full or empty.
//  Queue never overflows: the credit check counts the in-flight read.
//  Redirect (priority over everything): count<=0, ptrs<=0, inflight<=0,
//   pc<=redirect_pc. The ROM data arriving this cycle is dropped; no pop, no issue.
//   valid_d=0 in the cycle after redirect, regardless of stall_d.
//  Latency: redirect in cycle T -> redirect_pc issued in T+1
//   -> valid_d=1 with instr_d=ROM[redirect_pc] in T+3.
//   The same 3-cycle latency applies from reset release.
//  Throughput: 1 instr/cycle sustained with stall_d=0.
//   Holding stall_d fills the queue to DEPTH, then issue stops and pc freezes.
//  instr_d/pc_d are read combinationally from the head entry; queue storage itself
//   is not reset.
// STRUCTURE
//  fetch_pkg: INST_W/ADDR_W defaults; typedef fetch_entry_t {pc, instr}.
//  Sub-module fetch_fifo: generic DEPTH x fetch_entry_t sync FIFO.
//   Provides push, pop, flush, count, head; async active-low reset of ptrs/count.
//  Top level holds: PC register, inflight/inflight_pc, credit/issue logic,
//   redirect control.
// TESTING
//  1 Reset release, stall_d=0, ROM[i]=i+0x100:
//    valid_d rises in cycle 3; then pc_d=0,1,2,... with instr_d=0x100,0x101,...
//    one per cycle.
//  2 stall_d held high for 10 cycles:
//    count saturates at 4, rom_addr freezes, head stays pc_d=0.
//    Release -> 4 queued entries drain in order, then the stream continues
//    with no gap and no duplicate.
//  3 redirect=1, redirect_pc=0x0040 while full and stalled:
//    next cycle valid_d=0, count=0. valid_d returns 3 cycles after redirect
//    with pc_d=0x0040; no stale entry is ever popped.
//  4 Back-to-back redirects (0x10 then 0x20) on consecutive cycles:
//    only 0x20 stream is ever output.
//  5 pc=0xFFFF, PC_STEP=1: entry pc_d=0xFFFF is followed by pc_d=0x0000.
//  6 reset pulsed low mid-stream with count=3:
//    valid_d=0 and count=0 immediately (before the next edge).
//    Refetch starts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch prefetch queue.
//   INST_W_DEF / ADDR_W_DEF / DEPTH_DEF : default widths and queue depth
//   fetch_entry_t                      : one queued {pc, instr} pair at default widths
//   cnt_w()                            : width of an occupancy counter for a given depth
package fetch_queue_pkg;

    localparam int INST_W_DEF = 24;
    localparam int ADDR_W_DEF = 16;
    localparam int DEPTH_DEF  = 4;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [INST_W_DEF-1:0] instr;
    } fetch_entry_t;

    // Counter must hold the value DEPTH itself, hence the extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bus bundle between the fetch queue, the instruction ROM and the decode stage.
//   master : fetch queue side (drives rom_addr and the decode head outputs)
//   slave  : environment side (ROM data, decode stall, branch redirect)
//   rom_addr/rom_data           : ROM read port, data one cycle after address
//   stall_d, redirect, redirect_pc : decode-stage control
//   instr_d, pc_d, valid_d, count  : head entry and occupancy
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int INST_W = INST_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) ();
    localparam int CNT_W = cnt_w(DEPTH);

    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_data;
    logic              stall_d;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [INST_W-1:0] instr_d;
    logic [ADDR_W-1:0] pc_d;
    logic              valid_d;
    logic [CNT_W-1:0]  count;

    modport master (
        output rom_addr, instr_d, pc_d, valid_d, count,
        input  rom_data, stall_d, redirect, redirect_pc
    );

    modport slave (
        input  rom_addr, instr_d, pc_d, valid_d, count,
        output rom_data, stall_d, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_queue_fifo.sv
// Generic DEPTH-entry synchronous FIFO of entry_t.
//   clk, reset : clock, async active-low reset of pointers and count
//   push/wdata : write at tail
//   pop        : remove head
//   flush      : empty the queue (overrides push/pop)
//   count      : current occupancy
//   head       : entry at read pointer (undefined when count == 0)
// Storage is not reset; only pointers and count are.
module fetch_queue_fifo
    import fetch_queue_pkg::*;
#(
    parameter int  DEPTH   = DEPTH_DEF,
    parameter type entry_t = fetch_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  entry_t           wdata,
    output logic [CNT_W-1:0] count,
    output entry_t           head
);
    entry_t mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q] <= wdata;
    end

    assign count = count_q;
    assign head  = mem[rd_ptr_q];
endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage with prefetch queue between instruction ROM and decode.
//   clk   : clock (ROM shares it)
//   reset : asynchronous active-low reset
//   fq    : fetch_queue_if.master -- ROM port, decode head outputs, stall/redirect
// The fetch PC drives the ROM directly; a read issued in one cycle returns data
// the next, tracked by inflight/inflight_pc. Issue is throttled by a credit check
// that counts the in-flight read, so the queue can never overflow.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int INST_W   = INST_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int PC_STEP  = 1,
    parameter int RESET_PC = 0
) (
    input logic          clk,
    input logic          reset,
    fetch_queue_if.master fq
);
    localparam int CNT_W = cnt_w(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic             valid;
    logic             pop;
    logic             push;
    logic             issue;
    logic [CNT_W:0]   occ;
    logic [CNT_W-1:0] count;
    entry_t           head;
    entry_t           wdata;

    assign valid = (count != '0);

    always_comb begin
        pop   = valid & ~fq.stall_d & ~fq.redirect;
        push  = inflight_q & ~fq.redirect;
        // pop implies count >= 1, so occ cannot underflow.
        occ   = {1'b0, count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
        issue = ~fq.redirect & (occ < (CNT_W+1)'(DEPTH));

        wdata.pc    = inflight_pc_q;
        wdata.instr = fq.rom_data;

        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (fq.redirect) begin
            pc_d = fq.redirect_pc;
        end else if (issue) begin
            inflight_pc_d = pc_q;
            pc_d          = pc_q + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= ADDR_W'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_queue_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (fq.redirect),
        .wdata (wdata),
        .count (count),
        .head  (head)
    );

    assign fq.rom_addr = pc_q;
    assign fq.valid_d  = valid;
    assign fq.count    = count;
    assign fq.instr_d  = valid ? head.instr : '0;
    assign fq.pc_d     = valid ? head.pc    : '0;
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue. The ROM model returns addr + 0x100.
// Stimulus loads the expected {pc, instr} stream whenever it starts a new fetch
// stream (reset release, redirect); the monitor checks every pop against it.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int IW = 24;
    localparam int AW = 16;
    localparam int D  = 4;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queue_if #(.INST_W(IW), .ADDR_W(AW), .DEPTH(D)) fq ();

    fetch_queue #(
        .INST_W(IW), .ADDR_W(AW), .DEPTH(D), .PC_STEP(1), .RESET_PC(0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (fq)
    );

    // Synchronous ROM: ROM[a] = a + 0x100.
    always @(posedge clk) fq.rom_data <= IW'(fq.rom_addr) + 24'h100;

    exp_t          sb[$];
    exp_t          e;
    int            checks = 0;
    int            errors = 0;
    int            pops   = 0;
    logic [AW-1:0] last_pc;
    logic          have_last = 1'b0;
    logic          seen_wrap = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_stream(input logic [AW-1:0] start, input int n);
        logic [AW-1:0] p;
        sb.delete();
        for (int i = 0; i < n; i++) begin
            p = start + AW'(i);
            sb.push_back({p, IW'(p) + 24'h100});
        end
    endtask

    // Edges until valid_d is seen, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (fq.valid_d !== 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    // Monitor: every cycle in which decode takes the head, compare it.
    always @(negedge clk) begin
        if (reset === 1'b1 && fq.valid_d === 1'b1 && fq.stall_d === 1'b0 && fq.redirect === 1'b0) begin
            checks++;
            pops++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pop: pc_d %0h instr_d %0h with no entry expected", fq.pc_d, fq.instr_d);
            end else begin
                e = sb.pop_front();
                if (fq.pc_d !== e.pc || fq.instr_d !== e.instr) begin
                    errors++;
                    $display("FAIL pop_entry: got pc %0h instr %0h expected pc %0h instr %0h",
                             fq.pc_d, fq.instr_d, e.pc, e.instr);
                end
                if (have_last && last_pc == 16'hFFFF && fq.pc_d == 16'h0000) seen_wrap = 1'b1;
                last_pc   = fq.pc_d;
                have_last = 1'b1;
            end
        end
    end

    initial begin
        int n;
        int p0;
        logic [AW-1:0] hd;

        reset          = 1'b0;
        fq.stall_d     = 1'b0;
        fq.redirect    = 1'b0;
        fq.redirect_pc = '0;
        #12;

        // Reset state
        check("rst_valid", 32'(fq.valid_d), 32'd0);
        check("rst_count", 32'(fq.count), 32'd0);
        check("rst_rom_addr", 32'(fq.rom_addr), 32'd0);
        check("rst_instr", 32'(fq.instr_d), 32'd0);
        check("rst_pc", 32'(fq.pc_d), 32'd0);

        // 1: release reset; release cycle is cycle 1, valid_d expected in cycle 3
        @(posedge clk); #1;
        load_stream(16'h0000, 64);
        reset = 1'b1;
        wait_valid(n);
        check("rst_latency_edges", 32'(n), 32'd2);
        check("first_pc", 32'(fq.pc_d), 32'h0);
        check("first_instr", 32'(fq.instr_d), 32'h100);
        for (int i = 0; i < 6; i++) begin
            step();
            check("stream_valid", 32'(fq.valid_d), 32'd1);
        end

        // 2: stall fills queue, pc freezes, then drain with no gap
        fq.stall_d = 1'b1;
        repeat (10) step();
        check("stall_count_full", 32'(fq.count), 32'd4);
        hd = (sb.size() > 0) ? sb[0].pc : 16'hDEAD;
        check("stall_head_pc", 32'(fq.pc_d), 32'(hd));
        check("stall_rom_addr", 32'(fq.rom_addr), 32'(hd + 16'd4));
        repeat (2) step();
        check("stall_rom_addr_held", 32'(fq.rom_addr), 32'(hd + 16'd4));
        fq.stall_d = 1'b0;
        p0 = pops;
        for (int i = 0; i < 8; i++) begin
            step();
            check("drain_no_gap", 32'(fq.valid_d), 32'd1);
        end
        check("drain_pop_count", 32'(pops - p0), 32'd8);

        // 3: redirect while full and stalled
        fq.stall_d = 1'b1;
        repeat (6) step();
        check("pre_redirect_full", 32'(fq.count), 32'd4);
        fq.redirect    = 1'b1;
        fq.redirect_pc = 16'h0040;
        load_stream(16'h0040, 64);
        step();
        fq.redirect = 1'b0;
        check("redir_valid_t1", 32'(fq.valid_d), 32'd0);
        check("redir_count_t1", 32'(fq.count), 32'd0);
        fq.stall_d = 1'b0;
        step();
        check("redir_valid_t2", 32'(fq.valid_d), 32'd0);
        step();
        check("redir_valid_t3", 32'(fq.valid_d), 32'd1);
        check("redir_pc_t3", 32'(fq.pc_d), 32'h40);
        check("redir_instr_t3", 32'(fq.instr_d), 32'h140);
        repeat (6) step();

        // 4: back-to-back redirects, only the 0x20 stream may appear
        fq.redirect    = 1'b1;
        fq.redirect_pc = 16'h0010;
        sb.delete();
        step();
        fq.redirect_pc = 16'h0020;
        load_stream(16'h0020, 64);
        step();
        fq.redirect = 1'b0;
        wait_valid(n);
        check("b2b_latency_edges", 32'(n), 32'd2);
        check("b2b_first_pc", 32'(fq.pc_d), 32'h20);
        repeat (6) step();

        // 5: PC wrap 0xFFFF -> 0x0000
        fq.redirect    = 1'b1;
        fq.redirect_pc = 16'hFFFE;
        load_stream(16'hFFFE, 64);
        step();
        fq.redirect = 1'b0;
        repeat (8) step();
        check("pc_wrap_seen", 32'(seen_wrap), 32'd1);

        // 6: async reset mid-stream with count = 3
        fq.stall_d = 1'b1;
        repeat (2) step();
        check("pre_reset_count", 32'(fq.count), 32'd3);
        reset = 1'b0;
        sb.delete();
        load_stream(16'h0000, 64);
        #1;
        check("async_rst_valid", 32'(fq.valid_d), 32'd0);
        check("async_rst_count", 32'(fq.count), 32'd0);
        check("async_rst_rom_addr", 32'(fq.rom_addr), 32'd0);
        @(posedge clk); #1;
        fq.stall_d = 1'b0;
        have_last  = 1'b0;
        reset      = 1'b1;
        wait_valid(n);
        check("rerst_latency_edges", 32'(n), 32'd2);
        check("rerst_first_pc", 32'(fq.pc_d), 32'h0);
        p0 = pops;
        repeat (6) step();
        check("rerst_pop_count", 32'(pops - p0), 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
